// File: rtl/coin_accumulator.sv
// Coin accumulator: synchronises two coin sensors, counts coins per
// denomination and hands the total to a sale stage or refunds it.
`timescale 1ns/1ps
module coin_accumulator #(
    parameter int TIMEOUT_CYC = 1000,
    parameter int MAX_COINS   = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin5_in,
    input  logic       coin10_in,
    input  logic       choice,
    input  logic       confirm,
    input  logic       cancel,
    output logic       txn_valid,
    input  logic       txn_ready,
    output logic [4:0] txn_n5,
    output logic [4:0] txn_n10,
    output logic [8:0] txn_total,
    output logic       txn_choice,
    output logic       refund_valid,
    output logic       coin_reject,
    output logic       busy
);

    localparam int IW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IW-1:0] TLAST = IW'(TIMEOUT_CYC - 1);
    localparam logic [4:0] MAXC = 5'(MAX_COINS);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        OFFER,
        REFUND
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2:0]    s5;
    logic [2:0]    s10;
    logic [2:0]    warm;
    logic [4:0]    n5;
    logic [4:0]    n10;
    logic [IW-1:0] idle_cnt;
    logic          det5;
    logic          det10;
    logic          accept;
    logic          inc5;
    logic          inc10;
    logic          clear;
    logic          capture;

    // warm marks when the edge-history flop holds a real sample, so a
    // sensor already high at reset release is not mistaken for an edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s5   <= '0;
            s10  <= '0;
            warm <= '0;
        end else begin
            s5   <= {s5[1:0], coin5_in};
            s10  <= {s10[1:0], coin10_in};
            warm <= {warm[1:0], 1'b1};
        end
    end

    assign det5  = warm[2] & s5[1] & ~s5[2];
    assign det10 = warm[2] & s10[1] & ~s10[2];

    assign accept = (state == IDLE) || (state == COLLECT);
    assign inc5   = det5 & accept & (n5 != MAXC);
    assign inc10  = det10 & accept & (n10 != MAXC);

    assign coin_reject = (det5 & ~inc5) | (det10 & ~inc10);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clear        = 1'b0;
        capture      = 1'b0;
        txn_valid    = 1'b0;
        refund_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (inc5 || inc10) state_nxt = COLLECT;
            end
            COLLECT: begin
                if (cancel) begin
                    state_nxt = REFUND;
                end else if (confirm && (txn_total != 9'd0)) begin
                    state_nxt = OFFER;
                    capture   = 1'b1;
                end else if (!(inc5 || inc10) && (idle_cnt == TLAST)) begin
                    state_nxt = REFUND;
                end
            end
            OFFER: begin
                txn_valid = 1'b1;
                if (txn_ready) begin
                    state_nxt = IDLE;
                    clear     = 1'b1;
                end
            end
            REFUND: begin
                refund_valid = 1'b1;
                state_nxt    = IDLE;
                clear        = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (state != COLLECT || inc5 || inc10 || confirm) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TLAST) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n5  <= '0;
            n10 <= '0;
        end else if (clear) begin
            n5  <= '0;
            n10 <= '0;
        end else begin
            if (inc5) n5 <= n5 + 5'd1;
            if (inc10) n10 <= n10 + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txn_choice <= 1'b0;
        end else if (capture) begin
            txn_choice <= choice;
        end else if (clear) begin
            txn_choice <= 1'b0;
        end
    end

    assign txn_n5    = n5;
    assign txn_n10   = n10;
    assign txn_total = ({4'b0, n5} << 2) + {4'b0, n5}
                     + ({4'b0, n10} << 3) + ({4'b0, n10} << 1);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_coin_accumulator.sv
// Scoreboard bench for coin_accumulator: stimulus queues expected
// transfers/refunds, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_coin_accumulator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin5_in = 1'b0;
    logic       coin10_in = 1'b0;
    logic       choice = 1'b0;
    logic       confirm = 1'b0;
    logic       cancel = 1'b0;
    logic       txn_ready = 1'b0;
    logic       txn_valid;
    logic [4:0] txn_n5;
    logic [4:0] txn_n10;
    logic [8:0] txn_total;
    logic       txn_choice;
    logic       refund_valid;
    logic       coin_reject;
    logic       busy;

    coin_accumulator #(.TIMEOUT_CYC(8), .MAX_COINS(31)) dut (
        .clk(clk),
        .reset(reset),
        .coin5_in(coin5_in),
        .coin10_in(coin10_in),
        .choice(choice),
        .confirm(confirm),
        .cancel(cancel),
        .txn_valid(txn_valid),
        .txn_ready(txn_ready),
        .txn_n5(txn_n5),
        .txn_n10(txn_n10),
        .txn_total(txn_total),
        .txn_choice(txn_choice),
        .refund_valid(refund_valid),
        .coin_reject(coin_reject),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int refund;
        int n5;
        int n10;
        int total;
        int choice;
        int cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int rej_cnt = 0;
    int vcyc = 0;
    int unstable = 0;
    logic [19:0] held;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic c5, input logic c10);
        coin5_in  = c5;
        coin10_in = c10;
        step();
        step();
        coin5_in  = 1'b0;
        coin10_in = 1'b0;
        step();
        step();
    endtask

    task automatic push(input int r, input int a, input int b,
                        input int t, input int c, input int y);
        exp_t e;
        e.refund = r;
        e.n5     = a;
        e.n10    = b;
        e.total  = t;
        e.choice = c;
        e.cyc    = y;
        q.push_back(e);
    endtask

    task automatic do_confirm();
        confirm = 1'b1;
        step();
        confirm = 1'b0;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            vcyc     = 0;
            unstable = 0;
        end else begin
            if (coin_reject) rej_cnt++;
            if (txn_valid || refund_valid)
                check("valid_exclusive", int'(txn_valid & refund_valid), 0);
            if (txn_valid) begin
                if (vcyc == 0)
                    held = {txn_n5, txn_n10, txn_total, txn_choice};
                else if (held != {txn_n5, txn_n10, txn_total, txn_choice})
                    unstable = 1;
                vcyc++;
                if (txn_ready) begin
                    check("txn_expected", int'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check("txn_kind", 0, e.refund);
                        check("txn_n5", int'(txn_n5), e.n5);
                        check("txn_n10", int'(txn_n10), e.n10);
                        check("txn_total", int'(txn_total), e.total);
                        check("txn_choice", int'(txn_choice), e.choice);
                        check("txn_valid_cycles", vcyc, e.cyc);
                        check("txn_stable", unstable, 0);
                    end
                    vcyc     = 0;
                    unstable = 0;
                end
            end
            if (refund_valid) begin
                check("refund_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("refund_kind", 1, e.refund);
                    check("refund_n5", int'(txn_n5), e.n5);
                    check("refund_n10", int'(txn_n10), e.n10);
                    check("refund_total", int'(txn_total), e.total);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int waitc;
        int rej0;

        // reset state, coin5 sensor held high across release
        coin5_in = 1'b1;
        #12;
        check("rst_txn_valid", int'(txn_valid), 0);
        check("rst_refund_valid", int'(refund_valid), 0);
        check("rst_coin_reject", int'(coin_reject), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_total", int'(txn_total), 0);
        step();
        reset = 1'b0;
        repeat (6) step();
        check("held_coin_not_counted", int'(busy), 0);
        check("held_coin_no_reject", rej_cnt, 0);
        coin5_in = 1'b0;
        repeat (3) step();
        push(1, 1, 0, 5, 0, 0);
        pulse(1'b1, 1'b0);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        repeat (3) step();

        // two coin10, one coin5, choice 1, ready held high
        txn_ready = 1'b1;
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        choice = 1'b1;
        push(0, 1, 2, 25, 1, 1);
        do_confirm();
        choice = 1'b0;
        repeat (3) step();
        check("idle_after_txn", int'(busy), 0);
        txn_ready = 1'b0;

        // four coin10, ready low 5 cycles, coin5 during offer
        repeat (4) pulse(1'b0, 1'b1);
        rej0 = rej_cnt;
        push(0, 0, 4, 40, 0, 6);
        do_confirm();
        coin5_in = 1'b1;
        step();
        step();
        coin5_in = 1'b0;
        repeat (3) step();
        txn_ready = 1'b1;
        step();
        txn_ready = 1'b0;
        repeat (2) step();
        check("offer_coin_reject", rej_cnt - rej0, 1);

        // simultaneous coins, cancel and confirm together
        push(1, 1, 1, 15, 0, 0);
        pulse(1'b1, 1'b1);
        cancel  = 1'b1;
        confirm = 1'b1;
        step();
        cancel  = 1'b0;
        confirm = 1'b0;
        repeat (3) step();

        // idle timeout after a single coin5
        push(1, 1, 0, 5, 0, 0);
        pulse(1'b1, 1'b0);
        waitc = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (refund_valid) break;
            waitc++;
        end
        check("timeout_cycles", waitc, 8);
        repeat (3) step();

        // saturation at 31 coins, then reset while offering
        rej0 = rej_cnt;
        repeat (32) pulse(1'b1, 1'b0);
        check("sat_reject", rej_cnt - rej0, 1);
        do_confirm();
        @(negedge clk);
        check("sat_offer_valid", int'(txn_valid), 1);
        check("sat_n5", int'(txn_n5), 31);
        check("sat_total", int'(txn_total), 155);
        reset = 1'b1;
        #1;
        check("rst_mid_txn_valid", int'(txn_valid), 0);
        check("rst_mid_n5", int'(txn_n5), 0);
        check("rst_mid_total", int'(txn_total), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_refund", int'(refund_valid), 0);
        repeat (2) step();
        reset = 1'b0;
        repeat (5) step();
        check("post_rst_busy", int'(busy), 0);
        check("scoreboard_empty", q.size(), 0);
        check("total_rejects", rej_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
